// File: rtl/vend_pkg.sv
// Shared types, default tables and table-lookup helpers for the multi-product vending controller.
// Tables are packed vectors of equal-width entries; entry 0 sits in the least significant bits.
package vend_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDispWait,
        StDispense,
        StChgWait,
        StChgOut
    } state_e;

    localparam int unsigned TblW       = 256;
    localparam int unsigned MaxEntries = 8;

    localparam logic [63:0] DefPrices = {16'd100, 16'd70, 16'd50, 16'd30};
    localparam logic [79:0] DefCoins  = {16'd200, 16'd100, 16'd50, 16'd20, 16'd10};

    function automatic logic [31:0] tbl_entry(input logic [TblW-1:0] tbl,
                                              input int unsigned idx,
                                              input int unsigned w);
        logic [TblW-1:0] shifted;
        shifted = tbl >> (idx * w);
        return (w >= 32) ? shifted[31:0] : (shifted[31:0] & ((32'd1 << w) - 32'd1));
    endfunction

    function automatic logic coin_ok(input logic [31:0] value,
                                     input logic [TblW-1:0] tbl,
                                     input int unsigned num,
                                     input int unsigned w);
        logic ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < MaxEntries; i++) begin
            if (i < num && tbl_entry(tbl, i, w) == value) ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic logic [31:0] min_price(input logic [TblW-1:0] tbl,
                                              input int unsigned num,
                                              input int unsigned w);
        logic [31:0] m;
        m = '1;
        for (int unsigned i = 0; i < MaxEntries; i++) begin
            if (i < num && tbl_entry(tbl, i, w) < m) m = tbl_entry(tbl, i, w);
        end
        return m;
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter; done_o is high while the count is zero.
module vend_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          done_o
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin intake, priced selection with stock tracking,
// cancel/refund and change delivery over a valid/ready handshake.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int unsigned             NUM_PROD    = 4,
    parameter int unsigned             CW          = 16,
    parameter logic [NUM_PROD*CW-1:0]  PRICES      = DefPrices,
    parameter int unsigned             NUM_COINS   = 5,
    parameter logic [NUM_COINS*CW-1:0] COINS       = DefCoins,
    parameter int unsigned             MAX_CREDIT  = 500,
    parameter int unsigned             STOCK_W     = 8,
    parameter int unsigned             INIT_STOCK  = 10,
    parameter int unsigned             DISP_DLY    = 10,
    parameter int unsigned             CHG_DLY     = 20,
    parameter bit                      KEEP_CREDIT = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        coin_valid_i,
    input  logic [CW-1:0]               coin_value_i,
    input  logic                        sel_valid_i,
    input  logic [$clog2(NUM_PROD)-1:0] sel_id_i,
    input  logic                        cancel_i,
    input  logic                        restock_i,
    input  logic                        change_ready_i,
    output logic                        coin_reject_o,
    output logic                        sel_reject_o,
    output logic                        bev_valid_o,
    output logic [$clog2(NUM_PROD)-1:0] bev_id_o,
    output logic                        change_valid_o,
    output logic [CW-1:0]               change_value_o,
    output logic [CW-1:0]               credit_o,
    output logic [NUM_PROD-1:0]         sold_out_o,
    output logic                        busy_o
);

    localparam int unsigned IW = $clog2(NUM_PROD);
    localparam int unsigned TW = $clog2(((DISP_DLY > CHG_DLY) ? DISP_DLY : CHG_DLY) + 1);
    localparam logic [CW-1:0]      MinPrice  = CW'(min_price(TblW'(PRICES), NUM_PROD, CW));
    localparam logic [CW:0]        MaxCredit = (CW+1)'(MAX_CREDIT);
    localparam logic [IW:0]        NumProdW  = (IW+1)'(NUM_PROD);
    localparam logic [STOCK_W-1:0] InitStock = STOCK_W'(INIT_STOCK);
    localparam logic [TW-1:0]      DispLoad  = TW'(DISP_DLY - 1);
    localparam logic [TW-1:0]      ChgLoad   = TW'(CHG_DLY - 1);

    state_e             state_q;
    logic [CW-1:0]      credit_q, refund_q;
    logic [IW-1:0]      sel_id_q, bev_id_q;
    logic               coin_rej_q, sel_rej_q, bev_valid_q, chg_valid_q;
    logic [STOCK_W-1:0] stock_q [NUM_PROD];
    logic [15:0]        vend_cnt_q [NUM_PROD];
    logic [15:0]        refund_cnt_q, coin_rej_cnt_q;

    logic [CW-1:0] price_tbl [NUM_PROD];
    logic [CW-1:0] sel_price, residual;
    logic [CW:0]   coin_sum;
    logic [IW:0]   sel_ext;
    logic          idle, sel_ok, cancel_take, sel_take, coin_take, keep;
    logic          tmr_load, tmr_done;
    logic [TW-1:0] tmr_load_val;

    always_comb begin
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            price_tbl[i] = PRICES[i*CW +: CW];
        end
    end

    // Event arbitration in IDLE: cancel > selection > coin; anything not taken is rejected.
    always_comb begin
        idle        = (state_q == StIdle);
        sel_ext     = {1'b0, sel_id_i};
        sel_price   = (sel_ext < NumProdW) ? price_tbl[sel_id_i] : '0;
        sel_ok      = (sel_ext < NumProdW) && (credit_q >= sel_price)
                      && (stock_q[sel_id_i] != '0);
        cancel_take = idle && cancel_i && (credit_q != '0);
        sel_take    = idle && !cancel_take && sel_valid_i && sel_ok;
        coin_sum    = {1'b0, credit_q} + {1'b0, coin_value_i};
        coin_take   = idle && !cancel_take && !sel_take && coin_valid_i
                      && coin_ok(32'(coin_value_i), TblW'(COINS), NUM_COINS, CW)
                      && (coin_sum <= MaxCredit);
        residual    = credit_q - price_tbl[sel_id_q];
        keep        = (residual == '0) || (KEEP_CREDIT && (residual >= MinPrice));
        tmr_load    = sel_take || cancel_take || ((state_q == StDispense) && !keep);
        tmr_load_val = sel_take ? DispLoad : ChgLoad;
    end

    vend_timer #(
        .TW (TW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            credit_q       <= '0;
            refund_q       <= '0;
            sel_id_q       <= '0;
            bev_id_q       <= '0;
            coin_rej_q     <= 1'b0;
            sel_rej_q      <= 1'b0;
            bev_valid_q    <= 1'b0;
            chg_valid_q    <= 1'b0;
            refund_cnt_q   <= '0;
            coin_rej_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_PROD; i++) begin
                stock_q[i]    <= InitStock;
                vend_cnt_q[i] <= '0;
            end
        end else begin
            coin_rej_q  <= coin_valid_i && !coin_take;
            sel_rej_q   <= sel_valid_i && !sel_take;
            bev_valid_q <= 1'b0;
            if (coin_take) credit_q <= coin_sum[CW-1:0];
            if (coin_valid_i && !coin_take) coin_rej_cnt_q <= coin_rej_cnt_q + 16'd1;

            case (state_q)
                StIdle: begin
                    if (cancel_take) begin
                        refund_q <= credit_q;
                        state_q  <= StChgWait;
                    end else if (sel_take) begin
                        sel_id_q <= sel_id_i;
                        state_q  <= StDispWait;
                    end
                end
                StDispWait: begin
                    if (tmr_done) begin
                        bev_valid_q <= 1'b1;
                        bev_id_q    <= sel_id_q;
                        state_q     <= StDispense;
                    end
                end
                StDispense: begin
                    credit_q             <= residual;
                    vend_cnt_q[sel_id_q] <= vend_cnt_q[sel_id_q] + 16'd1;
                    if (stock_q[sel_id_q] != '0) begin
                        stock_q[sel_id_q] <= stock_q[sel_id_q] - STOCK_W'(1);
                    end
                    if (keep) begin
                        state_q <= StIdle;
                    end else begin
                        refund_q <= residual;
                        state_q  <= StChgWait;
                    end
                end
                StChgWait: begin
                    if (tmr_done) begin
                        chg_valid_q <= 1'b1;
                        state_q     <= StChgOut;
                    end
                end
                StChgOut: begin
                    if (change_ready_i) begin
                        chg_valid_q  <= 1'b0;
                        credit_q     <= '0;
                        refund_cnt_q <= refund_cnt_q + 16'd1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Reload wins over a same-cycle dispense decrement.
            if (restock_i) begin
                for (int unsigned i = 0; i < NUM_PROD; i++) stock_q[i] <= InitStock;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            sold_out_o[i] = (stock_q[i] == '0);
        end
    end

    assign coin_reject_o  = coin_rej_q;
    assign sel_reject_o   = sel_rej_q;
    assign bev_valid_o    = bev_valid_q;
    assign bev_id_o       = bev_id_q;
    assign change_valid_o = chg_valid_q;
    assign change_value_o = refund_q;
    assign credit_o       = credit_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: a default-policy instance and a KEEP_CREDIT=1 instance.
module tb_vend_ctrl_multi;

    localparam int DispDly = 10;
    localparam int ChgDly  = 20;
    localparam int Bound   = 200;

    logic        clk, rst_n;
    logic        coin_valid, sel_valid, cancel, restock, change_ready;
    logic [15:0] coin_value;
    logic [1:0]  sel_id;
    logic        coin_reject, sel_reject, bev_valid, change_valid, busy;
    logic [1:0]  bev_id;
    logic [15:0] change_value, credit;
    logic [3:0]  sold_out;

    logic        k_coin_valid, k_sel_valid, k_cancel, k_restock, k_change_ready;
    logic [15:0] k_coin_value;
    logic [1:0]  k_sel_id;
    logic        k_coin_reject, k_sel_reject, k_bev_valid, k_change_valid, k_busy;
    logic [1:0]  k_bev_id;
    logic [15:0] k_change_value, k_credit;
    logic [3:0]  k_sold_out;

    int n_checks = 0;
    int n_pass   = 0;

    vend_ctrl_multi #(
        .DISP_DLY    (DispDly),
        .CHG_DLY     (ChgDly),
        .KEEP_CREDIT (1'b0)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .coin_valid_i   (coin_valid),
        .coin_value_i   (coin_value),
        .sel_valid_i    (sel_valid),
        .sel_id_i       (sel_id),
        .cancel_i       (cancel),
        .restock_i      (restock),
        .change_ready_i (change_ready),
        .coin_reject_o  (coin_reject),
        .sel_reject_o   (sel_reject),
        .bev_valid_o    (bev_valid),
        .bev_id_o       (bev_id),
        .change_valid_o (change_valid),
        .change_value_o (change_value),
        .credit_o       (credit),
        .sold_out_o     (sold_out),
        .busy_o         (busy)
    );

    vend_ctrl_multi #(
        .DISP_DLY    (DispDly),
        .CHG_DLY     (ChgDly),
        .KEEP_CREDIT (1'b1)
    ) kdut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .coin_valid_i   (k_coin_valid),
        .coin_value_i   (k_coin_value),
        .sel_valid_i    (k_sel_valid),
        .sel_id_i       (k_sel_id),
        .cancel_i       (k_cancel),
        .restock_i      (k_restock),
        .change_ready_i (k_change_ready),
        .coin_reject_o  (k_coin_reject),
        .sel_reject_o   (k_sel_reject),
        .bev_valid_o    (k_bev_valid),
        .bev_id_o       (k_bev_id),
        .change_valid_o (k_change_valid),
        .change_value_o (k_change_value),
        .credit_o       (k_credit),
        .sold_out_o     (k_sold_out),
        .busy_o         (k_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [15:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic wait_bev(output int cyc);
        cyc = 0;
        while (bev_valid !== 1'b1 && cyc < Bound) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_chg(output int cyc);
        cyc = 0;
        while (change_valid !== 1'b1 && cyc < Bound) begin
            tick();
            cyc++;
        end
    endtask

    task automatic k_insert(input logic [15:0] v);
        k_coin_valid = 1'b1;
        k_coin_value = v;
        tick();
        k_coin_valid = 1'b0;
    endtask

    task automatic k_buy(input logic [1:0] id, output int cyc);
        k_sel_valid = 1'b1;
        k_sel_id    = id;
        tick();
        k_sel_valid = 1'b0;
        cyc = 0;
        while (k_bev_valid !== 1'b1 && cyc < Bound) begin
            tick();
            cyc++;
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {coin_valid, sel_valid, cancel, restock, change_ready} = '0;
        coin_value = '0;
        sel_id = '0;
        {k_coin_valid, k_sel_valid, k_cancel, k_restock, k_change_ready} = '0;
        k_coin_value = '0;
        k_sel_id = '0;
        repeat (3) tick();
        n_checks++;
        if (credit !== 16'd0) $display("FAIL reset_credit: got %0d want 0", credit);
        else n_pass++;
        n_checks++;
        if ({change_valid, bev_valid, coin_reject, sel_reject, busy} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {change_valid, bev_valid, coin_reject, sel_reject, busy});
        else n_pass++;
        n_checks++;
        if ({change_value, bev_id} !== 18'd0)
            $display("FAIL reset_values: got chg=%0d id=%0d want 0/0", change_value, bev_id);
        else n_pass++;
        n_checks++;
        if (sold_out !== 4'b0000 || dut.stock_q[3] !== 8'd10)
            $display("FAIL reset_stock: got sold_out=%b stock3=%0d want 0000/10",
                     sold_out, dut.stock_q[3]);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_vend_change();
        int cyc;
        insert(16'd20);
        n_checks++;
        if (coin_reject !== 1'b0) $display("FAIL coin20_accept: got rej=%b want 0", coin_reject);
        else n_pass++;
        insert(16'd20);
        n_checks++;
        if (credit !== 16'd40) $display("FAIL credit40: got %0d want 40", credit);
        else n_pass++;
        select(2'd0);
        n_checks++;
        if (sel_reject !== 1'b0 || busy !== 1'b1)
            $display("FAIL sel_accept: got rej=%b busy=%b want 0/1", sel_reject, busy);
        else n_pass++;
        wait_bev(cyc);
        // Selection cycle plus the waited ticks gives the selection-to-bev latency.
        n_checks++;
        if (cyc + 1 !== DispDly + 1)
            $display("FAIL bev_latency: got %0d want %0d", cyc + 1, DispDly + 1);
        else n_pass++;
        n_checks++;
        if (bev_id !== 2'd0) $display("FAIL bev_id0: got %0d want 0", bev_id);
        else n_pass++;
        tick();
        n_checks++;
        if (bev_valid !== 1'b0 || credit !== 16'd10 || dut.stock_q[0] !== 8'd9)
            $display("FAIL after_dispense: got bev=%b credit=%0d stock0=%0d want 0/10/9",
                     bev_valid, credit, dut.stock_q[0]);
        else n_pass++;
        wait_chg(cyc);
        n_checks++;
        if (cyc + 1 !== ChgDly + 1)
            $display("FAIL chg_latency: got %0d want %0d", cyc + 1, ChgDly + 1);
        else n_pass++;
        n_checks++;
        if (change_value !== 16'd10) $display("FAIL change10: got %0d want 10", change_value);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (change_valid !== 1'b1 || change_value !== 16'd10)
            $display("FAIL change_hold: got v=%b val=%0d want 1/10", change_valid, change_value);
        else n_pass++;
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        n_checks++;
        if (change_valid !== 1'b0 || credit !== 16'd0 || busy !== 1'b0)
            $display("FAIL handshake: got v=%b credit=%0d busy=%b want 0/0/0",
                     change_valid, credit, busy);
        else n_pass++;
    endtask

    task automatic test_rejects();
        int cyc;
        insert(16'd50);
        select(2'd3);
        n_checks++;
        if (sel_reject !== 1'b1 || credit !== 16'd50 || busy !== 1'b0)
            $display("FAIL sel_reject_price: got rej=%b credit=%0d busy=%b want 1/50/0",
                     sel_reject, credit, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (sel_reject !== 1'b0) $display("FAIL sel_reject_pulse: got %b want 0", sel_reject);
        else n_pass++;
        insert(16'd13);
        n_checks++;
        if (coin_reject !== 1'b1 || credit !== 16'd50)
            $display("FAIL coin13: got rej=%b credit=%0d want 1/50", coin_reject, credit);
        else n_pass++;
        insert(16'd200);
        insert(16'd200);
        insert(16'd50);
        n_checks++;
        if (coin_reject !== 1'b0 || credit !== 16'd500)
            $display("FAIL credit_at_max: got rej=%b credit=%0d want 0/500", coin_reject, credit);
        else n_pass++;
        insert(16'd10);
        n_checks++;
        if (coin_reject !== 1'b1 || credit !== 16'd500)
            $display("FAIL credit_over_max: got rej=%b credit=%0d want 1/500",
                     coin_reject, credit);
        else n_pass++;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        wait_chg(cyc);
        n_checks++;
        if (change_valid !== 1'b1 || change_value !== 16'd500)
            $display("FAIL refund500: got v=%b val=%0d want 1/500", change_valid, change_value);
        else n_pass++;
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || credit !== 16'd0)
            $display("FAIL cancel_zero_credit: got busy=%b credit=%0d want 0/0", busy, credit);
        else n_pass++;
    endtask

    task automatic test_cancel();
        int cyc;
        insert(16'd100);
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_value = 16'd10;
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        n_checks++;
        if (coin_reject !== 1'b1 || busy !== 1'b1 || credit !== 16'd100)
            $display("FAIL cancel_with_coin: got rej=%b busy=%b credit=%0d want 1/1/100",
                     coin_reject, busy, credit);
        else n_pass++;
        insert(16'd10);
        n_checks++;
        if (coin_reject !== 1'b1) $display("FAIL busy_coin_reject: got %b want 1", coin_reject);
        else n_pass++;
        select(2'd0);
        n_checks++;
        if (sel_reject !== 1'b1) $display("FAIL busy_sel_reject: got %b want 1", sel_reject);
        else n_pass++;
        wait_chg(cyc);
        // Three ticks already elapsed since the cancel cycle.
        n_checks++;
        if (cyc + 3 !== ChgDly + 1)
            $display("FAIL cancel_latency: got %0d want %0d", cyc + 3, ChgDly + 1);
        else n_pass++;
        n_checks++;
        if (change_value !== 16'd100) $display("FAIL refund100: got %0d want 100", change_value);
        else n_pass++;
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        n_checks++;
        if (credit !== 16'd0 || change_valid !== 1'b0)
            $display("FAIL cancel_done: got credit=%0d v=%b want 0/0", credit, change_valid);
        else n_pass++;
    endtask

    task automatic test_sold_out();
        int cyc;
        restock = 1'b1;
        tick();
        restock = 1'b0;
        n_checks++;
        if (dut.stock_q[0] !== 8'd10) $display("FAIL restock0: got %0d want 10", dut.stock_q[0]);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            insert(16'd20);
            insert(16'd10);
            select(2'd0);
            wait_bev(cyc);
            tick();
        end
        n_checks++;
        if (sold_out !== 4'b0001 || credit !== 16'd0 || busy !== 1'b0)
            $display("FAIL sold_out0: got so=%b credit=%0d busy=%b want 0001/0/0",
                     sold_out, credit, busy);
        else n_pass++;
        insert(16'd20);
        insert(16'd10);
        select(2'd0);
        n_checks++;
        if (sel_reject !== 1'b1 || credit !== 16'd30 || busy !== 1'b0)
            $display("FAIL sel_sold_out: got rej=%b credit=%0d busy=%b want 1/30/0",
                     sel_reject, credit, busy);
        else n_pass++;
        restock = 1'b1;
        tick();
        restock = 1'b0;
        n_checks++;
        if (sold_out !== 4'b0000) $display("FAIL restock_clear: got %b want 0000", sold_out);
        else n_pass++;
        select(2'd0);
        wait_bev(cyc);
        restock = 1'b1;
        tick();
        restock = 1'b0;
        n_checks++;
        if (dut.stock_q[0] !== 8'd10 || credit !== 16'd0)
            $display("FAIL restock_over_dispense: got stock0=%0d credit=%0d want 10/0",
                     dut.stock_q[0], credit);
        else n_pass++;
        n_checks++;
        if (dut.vend_cnt_q[0] !== 16'd12)
            $display("FAIL vend_cnt0: got %0d want 12", dut.vend_cnt_q[0]);
        else n_pass++;
    endtask

    task automatic test_keep_credit();
        int cyc;
        int seen;
        k_insert(16'd200);
        n_checks++;
        if (k_credit !== 16'd200) $display("FAIL keep_credit200: got %0d want 200", k_credit);
        else n_pass++;
        k_buy(2'd0, cyc);
        n_checks++;
        if (k_credit !== 16'd170 || k_busy !== 1'b0 || k_change_valid !== 1'b0)
            $display("FAIL keep_after_buy0: got credit=%0d busy=%b v=%b want 170/0/0",
                     k_credit, k_busy, k_change_valid);
        else n_pass++;
        seen = 0;
        repeat (30) begin
            tick();
            if (k_change_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL keep_no_change: got %0d change cycles want 0", seen);
        else n_pass++;
        k_buy(2'd3, cyc);
        n_checks++;
        if (k_credit !== 16'd70 || k_busy !== 1'b0)
            $display("FAIL keep_after_buy3: got credit=%0d busy=%b want 70/0", k_credit, k_busy);
        else n_pass++;
        // Residual 20 is below the cheapest price, so it is returned.
        k_buy(2'd1, cyc);
        cyc = 0;
        while (k_change_valid !== 1'b1 && cyc < Bound) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (k_change_valid !== 1'b1 || k_change_value !== 16'd20)
            $display("FAIL keep_small_residual: got v=%b val=%0d want 1/20",
                     k_change_valid, k_change_value);
        else n_pass++;
        k_change_ready = 1'b1;
        tick();
        k_change_ready = 1'b0;
        n_checks++;
        if (k_credit !== 16'd0 || k_busy !== 1'b0)
            $display("FAIL keep_done: got credit=%0d busy=%b want 0/0", k_credit, k_busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_change();
        int cyc;
        insert(16'd20);
        insert(16'd20);
        select(2'd0);
        wait_bev(cyc);
        tick();
        wait_chg(cyc);
        n_checks++;
        if (change_valid !== 1'b1 || dut.stock_q[0] !== 8'd9)
            $display("FAIL pre_reset: got v=%b stock0=%0d want 1/9", change_valid, dut.stock_q[0]);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (change_valid !== 1'b0 || credit !== 16'd0 || busy !== 1'b0)
            $display("FAIL async_reset: got v=%b credit=%0d busy=%b want 0/0/0",
                     change_valid, credit, busy);
        else n_pass++;
        n_checks++;
        if (dut.stock_q[0] !== 8'd10 || dut.stock_q[1] !== 8'd10 || change_value !== 16'd0)
            $display("FAIL async_reset_stock: got s0=%0d s1=%0d chg=%0d want 10/10/0",
                     dut.stock_q[0], dut.stock_q[1], change_value);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (credit !== 16'd0 || busy !== 1'b0)
            $display("FAIL post_reset: got credit=%0d busy=%b want 0/0", credit, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vend_change();
        test_rejects();
        test_cancel();
        test_sold_out();
        test_keep_credit();
        test_reset_mid_change();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
